// File: rtl/mem_stage_pipelined.sv
// MEM pipeline stage: branch resolution, data-memory load/store with
// configurable access latency, and the MEM/WB output registers.
//
// Handshake (EX/MEM side): an operation is accepted on a rising edge where
// in_valid && in_ready. in_ready is high only in IDLE. Upstream holds its
// inputs stable until accepted; inputs seen while BUSY are ignored.
// out_valid is a single-cycle pulse per accepted op; there is no WB back-pressure.
module mem_stage_pipelined #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,           // asynchronous, active-low
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              branch,
    input  logic              zero,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data,
    output logic              pc_src,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_to_reg_out,
    output logic              addr_fault,
    output logic              dbg_busy         // FSM state: 1 = BUSY
);

    localparam int CNT_W = 4;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               fire;
    logic               cap_en;
    logic               accept;
    logic               is_mem_in;

    // Operands captured at accept for multi-cycle memory ops
    logic               cap_read, cap_write, cap_m2r;
    logic [DATA_W-1:0]  cap_alu, cap_wdata;

    // Operands of the op completing this cycle
    logic               ex_read, ex_write, ex_m2r;
    logic [DATA_W-1:0]  ex_alu, ex_wdata;
    logic [ADDR_W-1:0]  ex_addr;
    logic [IDX_W-1:0]   ex_idx;
    logic               in_range;
    logic [DATA_W-1:0]  rd_word;

    logic [DATA_W-1:0]  mem [DEPTH];

    assign in_ready  = (state == IDLE);
    assign dbg_busy  = (state == BUSY);
    assign accept    = in_valid & in_ready;
    assign is_mem_in = mem_read | mem_write;
    assign pc_src    = in_valid & in_ready & branch & zero;

    // State and latency counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: single-cycle ops complete at accept, memory ops with
    // LATENCY>1 park in BUSY until the counter reaches 1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fire      = 1'b0;
        cap_en    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mem_in && (LATENCY > 1)) begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_W'(LATENCY - 1);
                        cap_en    = 1'b1;
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    fire      = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Capture operands when a multi-cycle access is accepted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
            cap_m2r   <= 1'b0;
            cap_alu   <= '0;
            cap_wdata <= '0;
        end else if (cap_en) begin
            cap_read  <= mem_read;
            cap_write <= mem_write;
            cap_m2r   <= mem_to_reg_in;
            cap_alu   <= alu_result_in;
            cap_wdata <= write_data;
        end
    end

    // Select live inputs for single-cycle completion, captured ones from BUSY
    always_comb begin
        ex_read  = mem_read;
        ex_write = mem_write;
        ex_m2r   = mem_to_reg_in;
        ex_alu   = alu_result_in;
        ex_wdata = write_data;
        if (state == BUSY) begin
            ex_read  = cap_read;
            ex_write = cap_write;
            ex_m2r   = cap_m2r;
            ex_alu   = cap_alu;
            ex_wdata = cap_wdata;
        end
    end

    // Address compared at full ADDR_W width; out-of-range reads return 0
    assign ex_addr  = ex_alu[ADDR_W-1:0];
    assign ex_idx   = ex_addr[IDX_W-1:0];
    assign in_range = ({1'b0, ex_addr} < DEPTH_L);
    assign rd_word  = in_range ? mem[ex_idx] : '0;

    // Data memory: cleared on reset; stores commit only on completion and in range
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (fire && ex_write && in_range) begin
            mem[ex_idx] <= ex_wdata;
        end
    end

    // MEM/WB registers: pulse out_valid, hold data until the next completion.
    // read_data samples the old word, so a combined read+write reads first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            alu_result_out <= '0;
            read_data      <= '0;
            mem_to_reg_out <= 1'b0;
            addr_fault     <= 1'b0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                alu_result_out <= ex_alu;
                read_data      <= ex_read ? rd_word : '0;
                mem_to_reg_out <= ex_m2r;
                addr_fault     <= (ex_read | ex_write) & ~in_range;
            end
        end
    end

endmodule
